// File: rtl/layer_generator_if.sv
// Handshake bundle between the jump controller (master) and the layer generator (slave).
interface layer_generator_if;
  logic        one_ms_tick;
  logic        game_active;
  logic        jump_req;
  logic        scroll_start;
  logic [0:6]  layer_map;
  logic [0:6]  block_type;
  logic        busy;
  logic [15:0] layers_done;

  modport master (
    output one_ms_tick, game_active, jump_req,
    input  scroll_start, layer_map, block_type, busy, layers_done
  );

  modport slave (
    input  one_ms_tick, game_active, jump_req,
    output scroll_start, layer_map, block_type, busy, layers_done
  );
endinterface

// File: rtl/layer_generator.sv
// Builds a reachable 7-column top layer from a free-running LFSR on each jump,
// then issues the scroll start and holds the map stable for the whole scroll.
module layer_generator #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [0:6]  INIT_MAP   = 7'b0001000,
  parameter int          MIN_BLOCKS = 2,
  parameter int          MAX_TRIES  = 8,
  parameter int          SCROLL_MS  = 150
) (
  input logic              clk,
  input logic              rst,
  layer_generator_if.slave bus
);

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int CW = (SCROLL_MS > 1) ? $clog2(SCROLL_MS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [TW-1:0] try_cnt;
  logic [CW-1:0] tick_cnt;
  logic [0:6]    prev;
  logic [0:6]    cand;
  logic [0:6]    ctype;
  logic [0:6]    reach;
  logic [2:0]    pop;
  logic          valid;

  logic          scroll_start;
  logic [0:6]    layer_map;
  logic [0:6]    block_type;
  logic          busy;
  logic [15:0]   layers_done;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    cand  = '0;
    ctype = '0;
    pop   = '0;
    for (int i = 0; i < 7; i++) begin
      cand[i]  = lfsr[i];
      ctype[i] = lfsr[7+i] & lfsr[i];
      pop      = pop + 3'(lfsr[i]);
    end
  end

  // Columns reachable from the previous layer: same column or one step sideways.
  assign reach = prev | (prev >> 1) | (prev << 1);
  assign valid = (int'(pop) >= MIN_BLOCKS) && ((cand & reach) != 7'b0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= SEED_EFF;
      try_cnt      <= '0;
      tick_cnt     <= '0;
      prev         <= INIT_MAP;
      layer_map    <= INIT_MAP;
      block_type   <= '0;
      scroll_start <= 1'b0;
      busy         <= 1'b0;
      layers_done  <= '0;
    end else begin
      lfsr         <= {lfsr_fb, lfsr[15:1]};
      scroll_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.jump_req && bus.game_active) begin
            state   <= GEN;
            try_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        GEN: begin
          if (valid) begin
            layer_map    <= cand;
            block_type   <= ctype;
            scroll_start <= 1'b1;
            state        <= ISSUE;
          end else if (try_cnt == TW'(MAX_TRIES - 1)) begin
            layer_map    <= prev;
            block_type   <= '0;
            scroll_start <= 1'b1;
            state        <= ISSUE;
          end else begin
            try_cnt <= try_cnt + 1'b1;
          end
        end
        ISSUE: begin
          prev     <= layer_map;
          tick_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // Leaves on the same tick that ends the scroll stages' scrolling state.
          if (bus.one_ms_tick) begin
            if (tick_cnt == CW'(SCROLL_MS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (layers_done != 16'hFFFF) begin
            layers_done <= layers_done + 16'd1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scroll_start = scroll_start;
  assign bus.layer_map    = layer_map;
  assign bus.block_type   = block_type;
  assign bus.busy         = busy;
  assign bus.layers_done  = layers_done;

endmodule

// File: tb/tb_layer_generator.sv
// Bench for layer_generator: table-driven jump vectors with a scoreboard of
// expected maps/latencies, plus hand sequences for fallback and mid-scroll reset.
module tb_layer_generator;

  localparam logic [0:6]  INIT_MAP  = 7'b0001000;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          SCROLL_MS = 150;

  typedef struct {
    logic ga;
    logic jr;
    logic tick;
    logic exp_busy;
    logic mid_jump;
    logic mid_drop;
    logic fast;
    int   rst_at;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [0:6] map;
    logic [0:6] btype;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  logic [15:0] m_lfsr;
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_done = 0;
  logic [0:6]  exp_prev = INIT_MAP;
  logic [0:6]  cur_map = INIT_MAP;
  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[8];

  layer_generator_if bus();
  layer_generator_if bus_full();

  layer_generator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  layer_generator #(.MIN_BLOCKS(8)) dut_full (
    .clk (clk),
    .rst (rst),
    .bus (bus_full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  // Reference generator: walks candidates from the LFSR value of the first GEN cycle.
  function automatic void model_gen(input logic [15:0] l_in, input logic [0:6] prev, input int minb,
                                    output logic [0:6] map, output logic [0:6] btype, output int n);
    logic [15:0] l;
    logic [0:8]  pad;
    int          pc;
    bit          hit;
    l     = l_in;
    pad   = {1'b0, prev, 1'b0};
    map   = prev;
    btype = '0;
    n     = 8;
    for (int t = 0; t < 8; t++) begin
      pc  = 0;
      hit = 0;
      for (int j = 0; j < 7; j++) begin
        pc += int'(l[j]);
        if (l[j] && (pad[j] || pad[j+1] || pad[j+2])) hit = 1;
      end
      if (pc >= minb && hit) begin
        for (int j = 0; j < 7; j++) begin
          map[j]   = l[j];
          btype[j] = l[j] & l[7+j];
        end
        n = t + 1;
        return;
      end
      l = lfsr_next(l);
    end
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.scroll_start) begin
      if (sb.size() == 0) begin
        check_output("unexpected_scroll_start", {31'b0, bus.scroll_start}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_output("scroll_latency", cyc, mon_e.cyc);
        check_output("layer_map", {25'b0, bus.layer_map}, {25'b0, mon_e.map});
        check_output("block_type", {25'b0, bus.block_type}, {25'b0, mon_e.btype});
        check_output("type_outside_map", {25'b0, bus.block_type & ~bus.layer_map}, 32'd0);
      end
    end
  end

  task automatic push_expect();
    logic [0:6] m;
    logic [0:6] b;
    int         n;
    exp_t       e;
    model_gen(m_lfsr, exp_prev, 2, m, b, n);
    e.cyc   = cyc + n;
    e.map   = m;
    e.btype = b;
    sb.push_back(e);
    exp_prev = m;
    cur_map  = m;
  endtask

  task automatic run_scroll(input vec_t v);
    int k;
    // Ticks held high through GEN and ISSUE must not be counted.
    bus.one_ms_tick = 1'b1;
    k = 0;
    while (!bus.scroll_start && k < 12) begin
      step();
      k++;
    end
    check_output("scroll_start_seen", {31'b0, bus.scroll_start}, 32'd1);
    if (!bus.scroll_start) begin
      bus.one_ms_tick = 1'b0;
      return;
    end
    for (int t = 1; t <= SCROLL_MS; t++) begin
      step();
      bus.jump_req = 1'b0;
      if (!v.fast) begin
        bus.one_ms_tick = 1'b0;
        step();
      end
      bus.one_ms_tick = 1'b1;
      if (v.mid_jump && t == 75) bus.jump_req = 1'b1;
      if (v.mid_drop && t == 60) bus.game_active = 1'b0;
      if (t == 100) begin
        check_output("busy_mid_scroll", {31'b0, bus.busy}, 32'd1);
        check_output("map_stable_mid", {25'b0, bus.layer_map}, {25'b0, cur_map});
      end
      if (t == v.rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.one_ms_tick = 1'b0;
        exp_prev = INIT_MAP;
        cur_map  = INIT_MAP;
        exp_done = 0;
        check_output("rst_layer_map", {25'b0, bus.layer_map}, {25'b0, INIT_MAP});
        check_output("rst_block_type", {25'b0, bus.block_type}, 32'd0);
        check_output("rst_busy", {31'b0, bus.busy}, 32'd0);
        check_output("rst_scroll_start", {31'b0, bus.scroll_start}, 32'd0);
        check_output("rst_layers_done", {16'b0, bus.layers_done}, 32'd0);
        repeat (5) step();
        check_output("rst_stays_idle", {31'b0, bus.busy}, 32'd0);
        return;
      end
    end
    check_output("busy_last_tick", {31'b0, bus.busy}, 32'd1);
    check_output("map_stable", {25'b0, bus.layer_map}, {25'b0, cur_map});
    step();
    bus.one_ms_tick = 1'b0;
    bus.jump_req    = 1'b0;
    check_output("busy_fall", {31'b0, bus.busy}, 32'd0);
    step();
    exp_done++;
    check_output("layers_done", {16'b0, bus.layers_done}, exp_done);
    check_output("map_after_scroll", {25'b0, bus.layer_map}, {25'b0, cur_map});
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.game_active = v.ga;
    bus.jump_req    = v.jr;
    bus.one_ms_tick = v.tick;
    step();
    bus.jump_req    = 1'b0;
    bus.one_ms_tick = 1'b0;
    if (v.exp_busy) push_expect();
    check_output("busy_after_jump", {31'b0, bus.busy}, {31'b0, v.exp_busy});
    if (v.exp_busy) begin
      run_scroll(v);
    end else begin
      repeat (3) step();
      check_output("ignored_busy", {31'b0, bus.busy}, 32'd0);
      check_output("map_held", {25'b0, bus.layer_map}, {25'b0, cur_map});
    end
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, wanted under 90000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:6] fm;
    logic [0:6] fb;
    int         fn;
    int         k;

    bus.game_active      = 1'b0;
    bus.jump_req         = 1'b0;
    bus.one_ms_tick      = 1'b0;
    bus_full.game_active = 1'b0;
    bus_full.jump_req    = 1'b0;
    bus_full.one_ms_tick = 1'b0;

    //             ga    jr    tick  busy  midj  drop  fast  rst_at
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check_output("idle_layer_map", {25'b0, bus.layer_map}, {25'b0, INIT_MAP});
    check_output("idle_block_type", {25'b0, bus.block_type}, 32'd0);
    check_output("idle_busy", {31'b0, bus.busy}, 32'd0);
    check_output("idle_layers_done", {16'b0, bus.layers_done}, 32'd0);

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

    // Impossible block minimum: GEN exhausts all tries and falls back to prev.
    bus_full.game_active = 1'b1;
    bus_full.jump_req    = 1'b1;
    step();
    bus_full.jump_req = 1'b0;
    model_gen(m_lfsr, INIT_MAP, 8, fm, fb, fn);
    check_output("full_busy", {31'b0, bus_full.busy}, 32'd1);
    k = 0;
    while (!bus_full.scroll_start && k < 12) begin
      step();
      k++;
    end
    check_output("full_latency", k, fn);
    check_output("full_map", {25'b0, bus_full.layer_map}, {25'b0, fm});
    check_output("full_type", {25'b0, bus_full.block_type}, {25'b0, fb});
    step();
    check_output("full_pulse_len", {31'b0, bus_full.scroll_start}, 32'd0);

    apply_stimulus('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 40});

    for (int s = 0; s < 200; s++) begin
      apply_stimulus('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0});
    end

    repeat (5) step();
    check_output("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
